// File: rtl/pes_pkg.sv
// pes_pkg: shared types and helpers for the frame/vector reverse stages.
//   state_t      - frame reverser control state (FILL, DRAIN)
//   bit_reverse  - reverses the low w bits of x (bit i <- bit w-1-i), zero above w
package pes_pkg;
    typedef enum logic {FILL, DRAIN} state_t;
    localparam int MAX_W  = 64;
    localparam int MAX_AW = $clog2(MAX_W);
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[MAX_AW'(i)] = x[MAX_AW'(w - 1 - i)];
        return r;
    endfunction
endpackage

// File: rtl/pes_frame_ram.sv
// pes_frame_ram: DEPTH x WIDTH frame buffer, one write port, one registered read port.
//   i_we/i_waddr/i_wdata - write port
//   i_re/i_raddr         - read request; o_rdata updates on the next edge only when i_re=1
//   o_rdata              - registered read data, cleared by rst; a same-cycle write to the
//                          read address is forwarded (write-first)
module pes_frame_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    always_ff @(posedge clk)
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/pes_frame_unreverse.sv
// pes_frame_unreverse: buffers a frame of up to DEPTH words and replays it last-first,
// optionally bit-reversing every word.
//   i_valid/o_ready/i_data/i_last - input stream (o_ready high only while filling)
//   o_valid/i_ready/o_data/o_last - output stream, registered, held while stalled
//   o_frame_len                   - length of the frame being drained
//   o_err_trunc                   - one-cycle pulse when a frame is cut at DEPTH words
module pes_frame_unreverse
    import pes_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int BIT_REV = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_last,
    output logic [$clog2(DEPTH):0] o_frame_len,
    output logic                   o_err_trunc
);
    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_valid, r_last, r_err;
    logic [AW:0]   r_frame_len;

    logic             w_accept, w_full, w_close, w_pop, w_next;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_wdata;

    assign o_ready  = r_state == FILL;
    assign w_accept = i_valid && o_ready;
    assign w_full   = r_wr_ptr == AW'(DEPTH - 1);
    assign w_close  = w_accept && (i_last || w_full);
    assign w_pop    = r_state == DRAIN && r_valid && i_ready;
    assign w_next   = w_pop && !r_last;
    // Words are stored already transformed, so the RAM output register is o_data.
    assign w_wdata  = (BIT_REV != 0) ? WIDTH'(bit_reverse(MAX_W'(i_data), WIDTH)) : i_data;
    // On close the closing word is read at its own write address; the RAM's
    // write-first forwarding delivers it to o_data without a separate bypass.
    assign w_raddr  = w_close ? r_wr_ptr : r_rd_ptr - AW'(1);

    pes_frame_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_close || w_next),
        .i_raddr (w_raddr),
        .o_rdata (o_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_frame_len <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && w_full && !i_last;
            if (r_state == FILL) begin
                if (w_close) begin
                    r_frame_len <= {1'b0, r_wr_ptr} + (AW + 1)'(1);
                    r_rd_ptr    <= r_wr_ptr;
                    r_valid     <= 1'b1;
                    r_last      <= r_wr_ptr == '0;
                    r_wr_ptr    <= '0;
                    r_state     <= DRAIN;
                end else if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end else if (w_pop) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= FILL;
                end else begin
                    r_rd_ptr <= r_rd_ptr - AW'(1);
                    r_last   <= r_rd_ptr == AW'(1);
                end
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_last      = r_last;
    assign o_frame_len = r_frame_len;
    assign o_err_trunc = r_err;
endmodule

// File: tb/tb_pes_frame_unreverse.sv
// tb_pes_frame_unreverse: directed checks of the frame reverser, pass-through and bit-reversing builds side by side.
module tb_pes_frame_unreverse;
    logic       clk = 1'b0, rst = 1'b1;
    logic       i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
    logic [7:0] i_data = '0;
    logic       o_ready0, o_valid0, o_last0, o_err0;
    logic       o_ready1, o_valid1, o_last1, o_err1;
    logic [7:0] o_data0, o_data1;
    logic [4:0] o_len0, o_len1;

    int         n_cmp = 0, n_err = 0;
    logic [7:0] q[$];
    int         exp_len = 0;

    always #5 clk = ~clk;

    pes_frame_unreverse #(.WIDTH(8), .DEPTH(16), .BIT_REV(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
        .i_last(i_last), .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0),
        .o_last(o_last0), .o_frame_len(o_len0), .o_err_trunc(o_err0)
    );

    pes_frame_unreverse #(.WIDTH(8), .DEPTH(16), .BIT_REV(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data),
        .i_last(i_last), .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1),
        .o_last(o_last1), .o_frame_len(o_len1), .o_err_trunc(o_err1)
    );

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7 - i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        check("in_ready0", 32'(o_ready0), 32'd1);
        check("in_ready1", 32'(o_ready1), 32'd1);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        q.push_back(d);
        @(negedge clk);
        if (l || q.size() == 16) exp_len = q.size();
        check("err_trunc0", 32'(o_err0), 32'(!l && q.size() == 16));
        check("err_trunc1", 32'(o_err1), 32'(!l && q.size() == 16));
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain(input int n, input logic [31:0] pat);
        int k = 0, c = 0;
        logic [7:0] e;
        while (k < n && c < 32) begin
            e = q[$];
            i_ready = pat[c];
            check("out_valid0", 32'(o_valid0), 32'd1);
            check("out_valid1", 32'(o_valid1), 32'd1);
            check("out_data0", 32'(o_data0), 32'(e));
            check("out_data1", 32'(o_data1), 32'(rev8(e)));
            check("out_last0", 32'(o_last0), 32'(q.size() == 1));
            check("out_last1", 32'(o_last1), 32'(q.size() == 1));
            check("frame_len0", 32'(o_len0), 32'(exp_len));
            check("frame_len1", 32'(o_len1), 32'(exp_len));
            check("in_ready_drain", 32'(o_ready0), 32'd0);
            @(negedge clk);
            if (pat[c]) begin
                e = q.pop_back();
                k++;
            end
            c++;
        end
        check("drain_budget", 32'(k), 32'(n));
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(o_valid0), 32'd0);
        check("rst_in_ready", 32'(o_ready0), 32'd1);
        check("rst_len", 32'(o_len0), 32'd0);
        check("rst_data", 32'(o_data0), 32'd0);
        check("rst_last", 32'(o_last0), 32'd0);
        check("rst_err", 32'(o_err0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h80, 1'b1);
        idle();
        drain(4, '1);
        check("t1_in_ready_back", 32'(o_ready0), 32'd1);

        push(8'h0F, 1'b1);
        idle();
        drain(1, '1);
        check("t2_in_ready_back", 32'(o_ready0), 32'd1);

        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        idle();
        drain(16, '1);
        check("t3_err_cleared", 32'(o_err0), 32'd0);
        for (int i = 16; i < 20; i++) push(8'(i), i == 19);
        idle();
        drain(4, '1);

        push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
        idle();
        drain(3, 32'h0000_0049);
        check("t4_in_ready_back", 32'(o_ready0), 32'd1);

        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), i == 7);
        idle();
        drain(2, '1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_valid", 32'(o_valid0), 32'd0);
        check("t5_valid1", 32'(o_valid1), 32'd0);
        check("t5_in_ready", 32'(o_ready0), 32'd1);
        check("t5_len", 32'(o_len0), 32'd0);
        check("t5_data", 32'(o_data0), 32'd0);
        q.delete();
        exp_len = 0;
        push(8'h11, 1'b0); push(8'h22, 1'b1);
        idle();
        drain(2, '1);

        push(8'h51, 1'b0); push(8'h52, 1'b0); push(8'h53, 1'b1);
        i_data = 8'h61;
        i_last = 1'b0;
        drain(3, '1);
        push(8'h61, 1'b0); push(8'h62, 1'b1);
        idle();
        drain(2, '1);
        check("t6_in_ready_back", 32'(o_ready0), 32'd1);
        check("t6_valid_low", 32'(o_valid0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pes_frame_unreverse.md
# pes_frame_unreverse

Streaming frame-order reverser: accepts a frame of up to DEPTH words on a valid/ready/last input stream, buffers it, then replays the words last-first on a valid/ready/last output stream. Each output word is optionally bit-reversed, which undoes the per-word bit reversal and word ordering applied upstream. The block sits between the reverse-vector stage and downstream consumers, and restores original element order at frame granularity.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: maximum frame length in words; power of two, ≥2.
- BIT_REV, 1: 1 = output word bits are reversed (bit i ← bit WIDTH-1-i); 0 = pass through unchanged.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input; combinational, equals (state == FILL).
- in_data  input  WIDTH  input word.
- in_last  input  1  marks final word of frame.
- out_valid  output  1  output word present; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  output word; registered.
- out_last  output  1  marks final output word, which is the first word received; registered.
- frame_len  output  $clog2(DEPTH)+1  length of the frame being drained; registered; held until the next drain starts.
- err_trunc  output  1  one-cycle pulse when a frame reaches DEPTH words without in_last.

## Operation
- States: FILL, DRAIN. Reset → FILL; wr_ptr=0, rd_ptr=0, out_valid=0, out_data=0, out_last=0, frame_len=0, err_trunc=0.
- FILL: in_ready=1. On in_valid && in_ready, write mem[wr_ptr]=in_data and increment wr_ptr.
- Frame close: the accepted word has in_last=1, or wr_ptr==DEPTH-1. On close:
  - frame_len = wr_ptr+1.
  - rd_ptr = wr_ptr.
  - out_data = f(in_data), bypassing memory.
  - out_valid=1.
  - out_last = (wr_ptr==0).
  - wr_ptr=0.
  - → DRAIN.
- Truncation: if the frame closes at wr_ptr==DEPTH-1 with in_last=0, err_trunc pulses in the same cycle the close registers. The remaining words of the upstream frame start a new frame.
- DRAIN: in_ready=0. On out_valid && out_ready:
  - If out_last=1: out_valid=0, out_last=0, → FILL.
  - Else: rd_ptr decrements; out_data = f(mem[rd_ptr-1]); out_last = (rd_ptr-1 == 0).
- f(x) = bit-reverse(x) when BIT_REV=1, else x.
- out_data, out_last and out_valid are stable while out_valid && !out_ready (AXI-style hold).
- Single-word frame: close at wr_ptr==0 gives out_last=1 immediately; frame_len=1.
- rst asserted mid-FILL or mid-DRAIN: the partial frame is discarded and all state returns to reset values on that edge. No output word is emitted after the reset edge.

## Timing
- Output latency: out_valid rises on the clock edge that accepts the closing input word, so it is visible the cycle after the handshake.
- Drain rate: one word per cycle while out_ready=1.
- Frame of N words: N accept cycles plus N emit cycles. in_ready returns the cycle after the out_last handshake.
- No overlap between fill and drain: in_ready=0 for the whole DRAIN state.
- Memory read is synchronous-compatible: the next word is fetched in the handshake cycle and registered into out_data.

## Structure
- Shared package pes_pkg holds:
  - the state enum (FILL, DRAIN);
  - a bit_reverse function parameterised by WIDTH, reused by the vector-reverse stage.
- One natural sub-module, pes_frame_ram: DEPTH×WIDTH, single write port, single read port, registered read. All other logic lives in the top level.

## Test plan
- 4-word frame 0x01,0x02,0x03,0x80 (last on 0x80), BIT_REV=1, out_ready=1 → out 0x01,0xC0,0x40,0x80; out_last on 0x80; frame_len=4; in_ready low for 4 cycles.
- Single-word frame 0x0F with in_last, BIT_REV=0 → out_valid the next cycle with 0x0F, out_last=1, frame_len=1.
- 20-word frame 0..19 with last on 19, DEPTH=16, BIT_REV=0 → err_trunc pulse on word 15. First drain emits 15..0. Second frame emits 19..16 with frame_len=4.
- Backpressure: 3-word frame 0xAA,0xBB,0xCC, out_ready toggled 1,0,0,1,… → out_data held stable while stalled; order 0xCC,0xBB,0xAA with BIT_REV=0.
- rst pulsed for 1 cycle after the second output word of an 8-word frame → next cycle out_valid=0, in_ready=1, frame_len=0. A new 2-word frame 0x11,0x22 then drains as 0x22,0x11.
- Back-to-back frames with in_valid held high → no word lost or duplicated; in_ready deasserted exactly during each DRAIN.
